// File: rtl/ct_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package : ct_buffer_pkg
// Desc    : Read-FSM state encoding and address-field width helpers.
// Rev     : 1.0
// ============================================================================
package ct_buffer_pkg;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_STREAM = 2'd1,
    R_DONE   = 2'd2
  } rd_state_t;

  // A field is never narrower than one bit so degenerate configs still elaborate.
  function automatic int limb_w(input int n_limbs);
    return (n_limbs > 1) ? $clog2(n_limbs) : 1;
  endfunction

  function automatic int beat_w(input int beats_per_limb);
    return (beats_per_limb > 1) ? $clog2(beats_per_limb) : 1;
  endfunction

  function automatic int addr_w(input int n_limbs, input int beats_per_limb);
    return 1 + limb_w(n_limbs) + beat_w(beats_per_limb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_bank.sv
`default_nettype none
// ============================================================================
// Module : bram_bank
// Desc   : Simple dual-port RAM, one write port, one registered read port.
// Rev    : 1.0
// ============================================================================
module bram_bank #(
  parameter int DATA_WIDTH = 54,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ct_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module : ct_pingpong_buffer
// Desc   : Two-half ping-pong ciphertext buffer over DP banks, limb-major.
// Rev    : 1.0
// ============================================================================
module ct_pingpong_buffer
  import ct_buffer_pkg::*;
#(
  parameter  int DATA_WIDTH     = 54,
  parameter  int DP             = 256,
  parameter  int N_LIMBS        = 4,
  parameter  int BEATS_PER_LIMB = 64,
  localparam int LIMB_W         = limb_w(N_LIMBS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [DP*DATA_WIDTH-1:0]   wr_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DP*DATA_WIDTH-1:0]   rd_data,
  input  logic                       rd_mode,
  input  logic [LIMB_W-1:0]          rd_limb_sel,
  output logic [LIMB_W-1:0]          rd_limb,
  output logic                       rd_last,
  output logic [1:0]                 full_cnt
);

  localparam int BEAT_W = beat_w(BEATS_PER_LIMB);
  localparam int ADDR_W = addr_w(N_LIMBS, BEATS_PER_LIMB);
  localparam int BUS_W  = DP * DATA_WIDTH;
  localparam logic [BEAT_W-1:0] c_beat_max = BEAT_W'(BEATS_PER_LIMB - 1);
  localparam logic [LIMB_W-1:0] c_limb_max = LIMB_W'(N_LIMBS - 1);

  // ---------------- write side ----------------
  logic [1:0]        r_full;
  logic              r_wr_half;
  logic [LIMB_W-1:0] r_wr_limb;
  logic [BEAT_W-1:0] r_wr_beat;
  logic              w_wr_fire;
  logic              w_wr_end;

  assign wr_ready  = !r_full[r_wr_half];
  assign w_wr_fire = wr_valid && wr_ready;
  assign w_wr_end  = (r_wr_beat == c_beat_max) && (r_wr_limb == c_limb_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_half <= 1'b0;
      r_wr_limb <= '0;
      r_wr_beat <= '0;
    end else if (w_wr_fire) begin
      if (w_wr_end) begin
        r_wr_half <= ~r_wr_half;
        r_wr_limb <= '0;
        r_wr_beat <= '0;
      end else if (r_wr_beat == c_beat_max) begin
        r_wr_beat <= '0;
        r_wr_limb <= r_wr_limb + LIMB_W'(1);
      end else begin
        r_wr_beat <= r_wr_beat + BEAT_W'(1);
      end
    end
  end

  // ---------------- read side ----------------
  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic              r_rd_half;
  logic              r_mode;
  logic [LIMB_W-1:0] r_rd_limb;
  logic [BEAT_W-1:0] r_rd_beat;
  logic              w_start;
  logic              w_issue;
  logic              w_release;
  logic              w_room;
  logic              w_pop;
  logic              w_iss_mode;
  logic [LIMB_W-1:0] w_iss_limb;
  logic [BEAT_W-1:0] w_iss_beat;
  logic              w_iss_last;

  logic              r_inflight;
  logic [LIMB_W-1:0] r_if_limb;
  logic              r_if_last;

  logic [BUS_W-1:0]  r_sk_data [2];
  logic [LIMB_W-1:0] r_sk_limb [2];
  logic [1:0]        r_sk_last;
  logic              r_sk_rp;
  logic              r_sk_wp;
  logic [1:0]        r_sk_cnt;

  // Sets and clears always target opposite halves, so both apply in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 2'b00;
    end else begin
      for (int h = 0; h < 2; h++) begin
        if (w_wr_fire && w_wr_end && (r_wr_half == 1'(h)))
          r_full[h] <= 1'b1;
        else if (w_release && (r_rd_half == 1'(h)))
          r_full[h] <= 1'b0;
      end
    end
  end

  assign full_cnt = {1'b0, r_full[0]} + {1'b0, r_full[1]};

  assign w_pop  = rd_valid && rd_ready;
  // Beats held plus the one in the BRAM pipe must leave a slot after this cycle's pop.
  assign w_room = ({1'b0, r_sk_cnt} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

  // The first read is issued straight from R_IDLE using the live mode inputs.
  assign w_iss_mode = (r_state == R_IDLE) ? rd_mode : r_mode;
  assign w_iss_limb = (r_state == R_IDLE) ? (rd_mode ? rd_limb_sel : '0) : r_rd_limb;
  assign w_iss_beat = (r_state == R_IDLE) ? '0 : r_rd_beat;
  assign w_iss_last = (w_iss_beat == c_beat_max) && (w_iss_mode || (w_iss_limb == c_limb_max));

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_issue     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (r_full[r_rd_half] && w_room) begin
          w_start     = 1'b1;
          w_issue     = 1'b1;
          w_state_nxt = w_iss_last ? R_DONE : R_STREAM;
        end
      end
      R_STREAM: begin
        if (w_room) begin
          w_issue = 1'b1;
          if (w_iss_last) w_state_nxt = R_DONE;
        end
      end
      R_DONE: begin
        if (w_pop && rd_last) begin
          w_release   = 1'b1;
          w_state_nxt = R_IDLE;
        end
      end
      default: w_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_half <= 1'b0;
      r_mode    <= 1'b0;
      r_rd_limb <= '0;
      r_rd_beat <= '0;
    end else begin
      if (w_start) r_mode <= rd_mode;
      if (w_issue) begin
        if (w_iss_beat == c_beat_max) begin
          r_rd_beat <= '0;
          r_rd_limb <= w_iss_limb + LIMB_W'(1);
        end else begin
          r_rd_beat <= w_iss_beat + BEAT_W'(1);
          r_rd_limb <= w_iss_limb;
        end
      end
      if (w_release) r_rd_half <= ~r_rd_half;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_if_limb  <= '0;
      r_if_last  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_if_limb  <= w_iss_limb;
      r_if_last  <= w_iss_last;
    end
  end

  // ---------------- banks ----------------
  logic [BUS_W-1:0]  w_bram_rdata;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_wr_addr = {r_wr_half, r_wr_limb, r_wr_beat};
  assign w_rd_addr = {r_rd_half, w_iss_limb, w_iss_beat};

  for (genvar b = 0; b < DP; b++) begin : g_bank
    bram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_W)
    ) u_bank (
      .clk   (clk),
      .we    (w_wr_fire),
      .waddr (w_wr_addr),
      .wdata (wr_data[b*DATA_WIDTH +: DATA_WIDTH]),
      .re    (w_issue),
      .raddr (w_rd_addr),
      .rdata (w_bram_rdata[b*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // ---------------- output skid ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_sk_data[i] <= '0;
        r_sk_limb[i] <= '0;
      end
      r_sk_last <= 2'b00;
      r_sk_rp   <= 1'b0;
      r_sk_wp   <= 1'b0;
      r_sk_cnt  <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_sk_data[r_sk_wp] <= w_bram_rdata;
        r_sk_limb[r_sk_wp] <= r_if_limb;
        r_sk_last[r_sk_wp] <= r_if_last;
        r_sk_wp            <= ~r_sk_wp;
      end
      if (w_pop) r_sk_rp <= ~r_sk_rp;
      case ({r_inflight, w_pop})
        2'b10:   r_sk_cnt <= r_sk_cnt + 2'd1;
        2'b01:   r_sk_cnt <= r_sk_cnt - 2'd1;
        default: r_sk_cnt <= r_sk_cnt;
      endcase
    end
  end

  assign rd_valid = (r_sk_cnt != 2'd0);
  assign rd_data  = r_sk_data[r_sk_rp];
  assign rd_limb  = r_sk_limb[r_sk_rp];
  assign rd_last  = r_sk_last[r_sk_rp];

endmodule
`default_nettype wire
